// File: rtl/stream_mux_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : stream_pkg                                         |
// | Description : Shared constants and helpers for stream_mux_arb    |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
package stream_pkg;

    // Selection modes carried on the mode input
    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Channel index width; never narrower than one bit
    function automatic int sel_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Bit offset of channel idx inside a flattened bus of w-bit lanes
    function automatic int ch_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_mux_arb_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : stream_mux_arb_if                                  |
// | Description : Handshake bundle for the N:1 stream mux/arbiter    |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
interface stream_mux_arb_if
    import stream_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) ();
    localparam int SEL_W = sel_width(NUM_CH);

    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;

    // Environment side: producers, consumer and mode control
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    // Mux/arbiter side
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface
`default_nettype wire

// File: rtl/stream_mux_arb_rr_grant.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : rr_grant                                           |
// | Description : Combinational round-robin grant: rotate requests   |
// |               by ptr, pick lowest, rotate the winner back        |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module rr_grant #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  wire logic [NUM_CH-1:0] req,
    input  wire logic [SEL_W-1:0]  ptr,
    output logic      [NUM_CH-1:0] grant,
    output logic      [SEL_W-1:0]  gidx,
    output logic                   any
);
    logic [NUM_CH-1:0]   w_rot;
    logic [NUM_CH-1:0]   w_rot_first;
    logic [2*NUM_CH-1:0] w_unrot;

    // Rotate so that channel ptr sits at bit 0; ptr is always < NUM_CH
    assign w_rot = NUM_CH'({req, req} >> ptr);

    // Lowest set bit of the rotated vector has highest priority
    assign w_rot_first = w_rot & (~w_rot + NUM_CH'(1));

    // Rotate the winner back to its real channel position
    assign w_unrot = {w_rot_first, w_rot_first} << ptr;
    assign grant   = w_unrot[2*NUM_CH-1:NUM_CH];
    assign any     = |req;

    // Encode the one-hot grant into a channel index
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) gidx = SEL_W'(i);
        end
    end
endmodule
`default_nettype wire

// File: rtl/stream_mux_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : stream_mux_arb                                     |
// | Description : NUM_CH:1 valid/ready stream mux with explicit or   |
// |               round-robin selection and a registered output      |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module stream_mux_arb
    import stream_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    stream_mux_arb_if.slave bus
);
    localparam int SEL_W = sel_width(NUM_CH);

    logic [NUM_CH-1:0] w_rr_grant;
    logic [SEL_W-1:0]  w_rr_gidx;
    logic              w_rr_any;
    logic [NUM_CH-1:0] w_sel_grant;
    logic [NUM_CH-1:0] w_grant;
    logic [SEL_W-1:0]  w_gidx;
    logic              w_any;
    logic              w_load;
    logic              w_xfer;
    logic [DATA_W-1:0] w_data;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SEL_W-1:0]  r_out_ch;
    logic [SEL_W-1:0]  r_rr_ptr;

    rr_grant #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_grant (
        .req   (bus.in_valid),
        .ptr   (r_rr_ptr),
        .grant (w_rr_grant),
        .gidx  (w_rr_gidx),
        .any   (w_rr_any)
    );

    // Explicit select: an out-of-range index grants nothing
    always_comb begin
        w_sel_grant = '0;
        if (int'(bus.sel) < NUM_CH) begin
            w_sel_grant = bus.in_valid & (NUM_CH'(1) << bus.sel);
        end
    end

    // Mode mux of the grant; the output register accepts when empty or draining
    assign w_grant = (bus.mode == MODE_RR) ? w_rr_grant : w_sel_grant;
    assign w_gidx  = (bus.mode == MODE_RR) ? w_rr_gidx  : bus.sel;
    assign w_any   = (bus.mode == MODE_RR) ? w_rr_any   : (|w_sel_grant);
    assign w_load  = !r_out_valid || bus.out_ready;
    assign w_xfer  = w_any && w_load && !rst;
    assign w_data  = DATA_W'(bus.in_data >> ch_lsb(int'(w_gidx), DATA_W));

    assign bus.in_ready  = w_xfer ? w_grant : '0;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_ch    <= w_gidx;
            if (bus.mode == MODE_RR) begin
                r_rr_ptr <= (w_gidx == SEL_W'(NUM_CH - 1)) ? '0 : w_gidx + SEL_W'(1);
            end
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_stream_mux_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_stream_mux_arb                                  |
// | Description : Scoreboard bench for stream_mux_arb (4 and 3 ch)   |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module tb_stream_mux_arb;
    import stream_pkg::*;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    stream_mux_arb_if #(.NUM_CH(4), .DATA_W(8)) bus4 ();
    stream_mux_arb_if #(.NUM_CH(3), .DATA_W(8)) bus3 ();

    stream_mux_arb #(.NUM_CH(4), .DATA_W(8)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    stream_mux_arb #(.NUM_CH(3), .DATA_W(8)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int data);
        exp_t e;
        e.ch   = 2'(ch);
        e.data = 8'(data);
        sb_q.push_back(e);
    endtask

    // Words leaving the 4-channel DUT are matched against the scoreboard
    always @(negedge clk) begin
        if (!rst && bus4.out_valid && bus4.out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_ch", bus4.out_ch, e.ch);
                check("sb_data", bus4.out_data, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus4.mode      = MODE_RR;
        bus4.sel       = 2'd0;
        bus4.in_valid  = 4'hF;
        bus4.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        bus4.out_ready = 1'b1;
        bus3.mode      = MODE_SEL;
        bus3.sel       = 2'd3;
        bus3.in_valid  = 3'b111;
        bus3.in_data   = {8'h32, 8'h31, 8'h30};
        bus3.out_ready = 1'b1;

        // Reset held with every channel requesting
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_out_valid", bus4.out_valid, 0);
            check("rst_out_data", bus4.out_data, 0);
            check("rst_out_ch", bus4.out_ch, 0);
            check("rst_in_ready", bus4.in_ready, 0);
        end
        rst = 1'b0;
        #1;

        // Round-robin with all channels valid: 0,1,2,3,0,1 back to back
        for (int i = 0; i < 6; i++) begin
            check("rr_in_ready", bus4.in_ready, 32'd1 << (i % 4));
            push(i % 4, 8'h10 + (i % 4));
            tick();
            check("rr_no_bubble", bus4.out_valid, 1);
        end

        // Explicit select of channel 2, one word per cycle
        bus4.mode     = MODE_SEL;
        bus4.sel      = 2'd2;
        bus4.in_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            bus4.in_data[23:16] = 8'(8'hA5 + i);
            #1;
            check("sel_in_ready", bus4.in_ready, 4'b0100);
            if (i < 2) push(2, 8'hA5 + i);
            tick();
            check("sel_out_valid", bus4.out_valid, 1);
        end

        // Reset with a word pending and rr_ptr at 2: the word is dropped
        rst            = 1'b1;
        bus4.out_ready = 1'b0;
        bus4.in_valid  = 4'h0;
        bus4.mode      = MODE_RR;
        tick();
        check("midrst_out_valid", bus4.out_valid, 0);
        check("midrst_out_data", bus4.out_data, 0);
        check("midrst_out_ch", bus4.out_ch, 0);
        rst            = 1'b0;
        bus4.in_valid  = 4'hF;
        bus4.out_ready = 1'b1;
        #1;
        check("midrst_rr_ch0", bus4.in_ready, 4'b0001);

        // Sparse round-robin: only channels 1 and 3 request
        bus4.in_valid       = 4'b1010;
        bus4.in_data[15:8]  = 8'h21;
        bus4.in_data[31:24] = 8'h23;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("sparse_in_ready", bus4.in_ready, (i % 2 == 0) ? 4'b0010 : 4'b1000);
            push((i % 2 == 0) ? 1 : 3, (i % 2 == 0) ? 8'h21 : 8'h23);
            tick();
        end
        bus4.in_valid = 4'h0;
        tick();

        // Backpressure: 0x3C from ch0 held for four cycles
        bus4.in_data[7:0] = 8'h3C;
        bus4.in_valid     = 4'b0001;
        push(0, 8'h3C);
        tick();
        bus4.out_ready     = 1'b0;
        bus4.in_valid      = 4'hF;
        bus4.in_data[15:8] = 8'h11;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("bp_in_ready", bus4.in_ready, 0);
            check("bp_out_valid", bus4.out_valid, 1);
            check("bp_out_data", bus4.out_data, 8'h3C);
            check("bp_out_ch", bus4.out_ch, 0);
            tick();
        end
        bus4.out_ready = 1'b1;
        #1;
        check("bp_resume_ch1", bus4.in_ready, 4'b0010);
        push(1, 8'h11);
        tick();
        check("bp_no_bubble", bus4.out_valid, 1);
        bus4.in_valid = 4'h0;
        tick();

        // Three-channel instance: sel=3 is out of range
        check("oor_in_ready", bus3.in_ready, 0);
        check("oor_out_valid", bus3.out_valid, 0);
        bus3.sel = 2'd1;
        #1;
        check("n3_sel_in_ready", bus3.in_ready, 3'b010);
        tick();
        check("n3_sel_out_valid", bus3.out_valid, 1);
        check("n3_sel_out_ch", bus3.out_ch, 1);
        check("n3_sel_out_data", bus3.out_data, 8'h31);

        // Three-channel round-robin must wrap 2 -> 0
        bus3.mode = MODE_RR;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("n3_rr_in_ready", bus3.in_ready, 32'd1 << (i % 3));
            tick();
            check("n3_rr_out_ch", bus3.out_ch, i % 3);
            check("n3_rr_out_data", bus3.out_data, 8'h30 + (i % 3));
        end
        bus3.in_valid = 3'b000;
        tick();

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
